gf180mcu_fd_sc_mcu9t5v0__addf_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor built from the full-adder cell function. It partitions a WIDTH-bit add into STAGES equal carry-ripple slices separated by register banks, so long-word adds close timing at the 5 V 9-track library's clock targets. A valid/ready handshake with a global stall provides back-pressure. Signed-overflow detection and a per-transaction add/subtract mode extend the single-bit cell.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__addf_pipe.sv | 195 +++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__addf_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addf_pipe.sv
// Pipelined ripple-carry adder/subtractor built from full-adder slices, with signed overflow output.
// Latency: STAGES register stages from the accepting edge to a valid S/CO/OVF.
// Backpressure: global stall; IN_READY = ~OUT_VALID | OUT_READY, and every stage holds while it is low.
module gf180mcu_fd_sc_mcu9t5v0__addf_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int W = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("addf_pipe: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic              adv;
    logic              accept;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_q;

    assign adv       = ~vld_q[STAGES-1] | OUT_READY;
    assign accept    = IN_VALID & adv;
    assign b_eff     = B ^ {WIDTH{SUB}};
    assign IN_READY  = adv;
    assign OUT_VALID = vld_q[STAGES-1];

    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = accept;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stage k keeps the finished low sum bits and the still-unused high operand bits.
    // B is stored already inverted for subtract, so SUB never travels down the pipe.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
        localparam int SW = (k + 1) * W;
        localparam int RW = WIDTH - SW;

        logic [W-1:0]  a_sl;
        logic [W-1:0]  b_sl;
        logic [W-1:0]  s_sl;
        logic          cin;
        logic          ld;
        logic          c_n;
        logic [SW-1:0] sum_n;
        logic [RW-1:0] a_n;
        logic [RW-1:0] b_n;
        logic [SW-1:0] sum_d;
        logic [SW-1:0] sum_q;
        logic [RW-1:0] a_d;
        logic [RW-1:0] a_q;
        logic [RW-1:0] b_d;
        logic [RW-1:0] b_q;
        logic          c_d;
        logic          c_q;

        if (k == 0) begin : g_src
            assign a_sl  = A[W-1:0];
            assign b_sl  = b_eff[W-1:0];
            assign cin   = CI;
            assign ld    = accept;
            assign a_n   = A[WIDTH-1:W];
            assign b_n   = b_eff[WIDTH-1:W];
            assign sum_n = s_sl;
        end else begin : g_src
            assign a_sl  = g_st[k-1].a_q[W-1:0];
            assign b_sl  = g_st[k-1].b_q[W-1:0];
            assign cin   = g_st[k-1].c_q;
            assign ld    = adv & vld_q[k-1];
            assign a_n   = g_st[k-1].a_q[RW+W-1:W];
            assign b_n   = g_st[k-1].b_q[RW+W-1:W];
            assign sum_n = {s_sl, g_st[k-1].sum_q};
        end

        always_comb begin
            {c_n, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, cin};
        end

        // Data only moves with a valid token, so bubbles leave the registers untouched.
        always_comb begin
            sum_d = sum_q;
            a_d   = a_q;
            b_d   = b_q;
            c_d   = c_q;
            if (ld) begin
                sum_d = sum_n;
                a_d   = a_n;
                b_d   = b_n;
                c_d   = c_n;
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                sum_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
                c_q   <= 1'b0;
            end else begin
                sum_q <= sum_d;
                a_q   <= a_d;
                b_q   <= b_d;
                c_q   <= c_d;
            end
        end
    end

    logic [W-1:0]     f_a;
    logic [W-1:0]     f_b;
    logic [W-1:0]     f_s;
    logic             f_cin;
    logic             f_ld;
    logic             f_co;
    logic             msb_c;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             co_d;
    logic             co_q;
    logic             ovf_d;
    logic             ovf_q;

    if (STAGES == 1) begin : g_fin
        assign f_a   = A;
        assign f_b   = b_eff;
        assign f_cin = CI;
        assign f_ld  = accept;
        assign s_n   = f_s;
    end else begin : g_fin
        assign f_a   = g_st[STAGES-2].a_q;
        assign f_b   = g_st[STAGES-2].b_q;
        assign f_cin = g_st[STAGES-2].c_q;
        assign f_ld  = adv & vld_q[STAGES-2];
        assign s_n   = {f_s, g_st[STAGES-2].sum_q};
    end

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
    always_comb begin
        {f_co, f_s} = {1'b0, f_a} + {1'b0, f_b} + {{W{1'b0}}, f_cin};
        msb_c       = f_a[W-1] ^ f_b[W-1] ^ f_s[W-1];
    end

    always_comb begin
        s_d   = s_q;
        co_d  = co_q;
        ovf_d = ovf_q;
        if (f_ld) begin
            s_d   = s_n;
            co_d  = f_co;
            ovf_d = msb_c ^ f_co;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign S   = s_q;
    assign CO  = co_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__addf_pipe.sv
// Bench for the pipelined adder: fixed vectors, stalled random stream, mid-flight reset,
// 8-bit single/fully pipelined corners and an exhaustive 4-bit/2-stage sweep.
module tb_gf180mcu_fd_sc_mcu9t5v0__addf_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] a16, b16, s16;
    logic ci16, sub16, iv16, ir16, co16, ovf16, ov16, or16;
    logic [7:0] a8, b8, s8a, s8b;
    logic ci8, sub8, iv8, or8, ir8a, ir8b, co8a, co8b, ovf8a, ovf8b, ov8a, ov8b;
    logic [3:0] a4, b4, s4;
    logic ci4, sub4, iv4, ir4, co4, ovf4, ov4, or4;

    gf180mcu_fd_sc_mcu9t5v0__addf_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .CI(ci16), .SUB(sub16),
        .IN_VALID(iv16), .IN_READY(ir16), .S(s16), .CO(co16), .OVF(ovf16),
        .OUT_VALID(ov16), .OUT_READY(or16));
    gf180mcu_fd_sc_mcu9t5v0__addf_pipe #(.WIDTH(8), .STAGES(1)) u_dut8a (
        .CLK(clk), .RST(rst), .A(a8), .B(b8), .CI(ci8), .SUB(sub8),
        .IN_VALID(iv8), .IN_READY(ir8a), .S(s8a), .CO(co8a), .OVF(ovf8a),
        .OUT_VALID(ov8a), .OUT_READY(or8));
    gf180mcu_fd_sc_mcu9t5v0__addf_pipe #(.WIDTH(8), .STAGES(8)) u_dut8b (
        .CLK(clk), .RST(rst), .A(a8), .B(b8), .CI(ci8), .SUB(sub8),
        .IN_VALID(iv8), .IN_READY(ir8b), .S(s8b), .CO(co8b), .OVF(ovf8b),
        .OUT_VALID(ov8b), .OUT_READY(or8));
    gf180mcu_fd_sc_mcu9t5v0__addf_pipe #(.WIDTH(4), .STAGES(2)) u_dut4 (
        .CLK(clk), .RST(rst), .A(a4), .B(b4), .CI(ci4), .SUB(sub4),
        .IN_VALID(iv4), .IN_READY(ir4), .S(s4), .CO(co4), .OVF(ovf4),
        .OUT_VALID(ov4), .OUT_READY(or4));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain w-bit arithmetic; returns {ovf, co, s[15:0]}.
    function automatic logic [17:0] model(input int w, input int unsigned a, input int unsigned b,
                                          input logic ci, input logic sub);
        int unsigned mask, bb, tot, s, sa, sb, ss;
        logic co, ovf;
        mask = (32'd1 << w) - 32'd1;
        bb   = sub ? (~b & mask) : (b & mask);
        tot  = (a & mask) + bb + {31'd0, ci};
        s    = tot & mask;
        co   = ((tot >> w) & 32'd1) != 0;
        sa   = (a >> (w - 1)) & 32'd1;
        sb   = (bb >> (w - 1)) & 32'd1;
        ss   = (s >> (w - 1)) & 32'd1;
        ovf  = (sa == sb) && (ss != sa);
        return {ovf, co, 16'(s)};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;
    vec_t tbl[5];

    initial begin
        logic [15:0] s_prev;
        logic [17:0] q16[$];
        logic [17:0] q4[$];
        logic [17:0] exp_r;
        int acc, got, cyc, la, lb, idx;
        logic [9:0] ra, rb;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};

        rst = 1'b1;
        {a16, b16, ci16, sub16, iv16} = '0; or16 = 1'b1;
        {a8, b8, ci8, sub8, iv8} = '0; or8 = 1'b1;
        {a4, b4, ci4, sub4, iv4} = '0; or4 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, ov16}, 0);
        check("rst_s", {16'd0, s16}, 0);
        check("rst_co_ovf", {30'd0, co16, ovf16}, 0);
        check("rst_in_ready", {31'd0, ir16}, 1);
        rst = 1'b0;

        // Back-to-back table vectors: vector j must appear at iteration j+4, none before.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 3) check("tbl_latency", {31'd0, ov16}, 0);
            if (c >= 4) begin
                check("tbl_valid", {31'd0, ov16}, 1);
                check("tbl_result", {13'd0, ovf16, co16, s16},
                      {13'd0, tbl[c-4].ovf, tbl[c-4].co, tbl[c-4].s});
            end
            if (c < 5) begin
                a16 = tbl[c].a; b16 = tbl[c].b; ci16 = tbl[c].ci; sub16 = tbl[c].sub; iv16 = 1'b1;
            end else begin
                iv16 = 1'b0;
            end
        end

        // Random stream of 8 with a 3-cycle output stall.
        acc = 0; got = 0; cyc = 0; s_prev = '0;
        while ((acc < 8 || q16.size() > 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            or16 = !(cyc >= 6 && cyc <= 8);
            if (acc < 8) begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                ci16 = 1'($urandom); sub16 = 1'($urandom); iv16 = 1'b1;
            end else begin
                iv16 = 1'b0;
            end
            #1;
            if (!or16) begin
                check("stall_out_valid", {31'd0, ov16}, 1);
                check("stall_in_ready", {31'd0, ir16}, 0);
                if (cyc == 6) s_prev = s16;
                else check("stall_s_stable", {16'd0, s16}, {16'd0, s_prev});
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) check("stream_extra_result", 1, 0);
                else begin
                    exp_r = q16.pop_front();
                    check("stream_result", {14'd0, ovf16, co16, s16}, {14'd0, exp_r});
                end
                got++;
            end
            if (iv16 && ir16) begin
                q16.push_back(model(16, a16, b16, ci16, sub16));
                acc++;
            end
        end
        iv16 = 1'b0; or16 = 1'b1;
        check("stream_count", got, 8);
        check("stream_drained", {31'd0, q16.size() == 0}, 1);

        // Three transactions in flight, then an asynchronous reset.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'b1; sub16 = 1'b0; iv16 = 1'b1;
        end
        @(negedge clk);
        iv16 = 1'b0; rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, ov16}, 0);
        check("midrst_s", {16'd0, s16}, 0);
        check("midrst_co_ovf", {30'd0, co16, ovf16}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("postrst_no_valid", {31'd0, ov16}, 0);
        end

        // 8-bit corner on the single-stage and fully pipelined variants.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
        la = 0; lb = 0; ra = '0; rb = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            iv8 = 1'b0;
            if (ov8a && la == 0) begin la = c; ra = {ovf8a, co8a, s8a}; end
            if (ov8b && lb == 0) begin lb = c; rb = {ovf8b, co8b, s8b}; end
        end
        check("w8s1_latency", la, 1);
        check("w8s1_result", {22'd0, ra}, 32'h301);
        check("w8s8_latency", lb, 8);
        check("w8s8_result", {22'd0, rb}, 32'h301);

        // Exhaustive 4-bit sweep with random handshakes.
        idx = 0; got = 0; cyc = 0;
        while ((idx < 1024 || q4.size() > 0) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            or4 = ($urandom_range(0, 3) != 0);
            iv4 = (idx < 1024) && ($urandom_range(0, 1) != 0);
            a4 = 4'(idx); b4 = 4'(idx >> 4); ci4 = 1'(idx >> 8); sub4 = 1'(idx >> 9);
            #1;
            if (ov4 && or4) begin
                if (q4.size() == 0) check("w4_extra_result", 1, 0);
                else begin
                    exp_r = q4.pop_front();
                    check("w4_result", {14'd0, ovf4, co4, 12'd0, s4}, {14'd0, exp_r});
                end
                got++;
            end
            if (iv4 && ir4) begin
                q4.push_back(model(4, a4, b4, ci4, sub4));
                idx++;
            end
        end
        check("w4_count", got, 1024);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
